// File: rtl/k051962_tile_serializer.sv
// Tile pixel serializer: turns one gfx ROM word per tile into a stream of 4-bit
// pixel codes with their attribute, delayed by the fine horizontal scroll.
module k051962_tile_serializer #(
    parameter int COL_W    = 8,
    parameter int MAX_FINE = 7
) (
    input  logic             M24,
    input  logic             RES,
    input  logic             CE_PIX,
    input  logic             LOAD,
    input  logic             BEN,
    input  logic             HFLIP,
    input  logic [COL_W-1:0] COL,
    input  logic [31:0]      VC_DATA,
    input  logic [2:0]       FINE,
    output logic [3:0]       PIX,
    output logic [COL_W-1:0] PCOL,
    output logic             OPAQUE,
    output logic             TILE_DONE
);

    localparam int ENT_W = 4 + COL_W;

    // Pixel n occupies shifter nibble n, so nibble 0 is the next pixel out.
    function automatic logic [31:0] decode_tile(input logic [31:0] word, input logic flip);
        logic [31:0] r;
        int          b;
        r = 32'd0;
        for (int n = 0; n < 8; n++) begin
            b = flip ? n : (7 - n);
            r[4*n +: 4] = {word[24+b], word[16+b], word[8+b], word[b]};
        end
        return r;
    endfunction

    logic [31:0]      shift_r;
    logic [3:0]       count_r;
    logic [COL_W-1:0] col_r;
    logic [ENT_W-1:0] dly_r [MAX_FINE];

    logic [31:0]      decode_s;
    logic [ENT_W-1:0] head_s;
    logic [ENT_W-1:0] sel_s;
    logic [31:0]      fine_ext_s;
    logic [31:0]      fine_lim_s;

    assign decode_s   = BEN ? decode_tile(VC_DATA, HFLIP) : 32'd0;
    assign head_s     = (count_r != 4'd0) ? {shift_r[3:0], col_r} : {ENT_W{1'b0}};
    assign fine_ext_s = {29'd0, FINE};
    assign fine_lim_s = (fine_ext_s > 32'(MAX_FINE)) ? 32'(MAX_FINE) : fine_ext_s;

    // Fine-scroll tap select: FINE=0 bypasses the delay line.
    always_comb begin
        sel_s = head_s;
        for (int i = 0; i < MAX_FINE; i++) begin
            sel_s = (fine_lim_s == 32'(i + 1)) ? dly_r[i] : sel_s;
        end
    end

    // Tile shifter, remaining count, attribute latch and end-of-tile pulse.
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            shift_r   <= 32'd0;
            count_r   <= 4'd0;
            col_r     <= {COL_W{1'b0}};
            TILE_DONE <= 1'b0;
        end else if (CE_PIX) begin
            if (LOAD) begin
                // A load always wins, truncating any tile still in flight.
                shift_r   <= decode_s;
                col_r     <= BEN ? COL : {COL_W{1'b0}};
                count_r   <= 4'd8;
                TILE_DONE <= 1'b0;
            end else if (count_r != 4'd0) begin
                shift_r   <= {4'd0, shift_r[31:4]};
                count_r   <= count_r - 4'd1;
                TILE_DONE <= (count_r == 4'd1);
            end else begin
                TILE_DONE <= 1'b0;
            end
        end else begin
            TILE_DONE <= TILE_DONE;
        end
    end

    // Fine-scroll delay line, advanced once per pixel tick.
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            for (int i = 0; i < MAX_FINE; i++) begin
                dly_r[i] <= {ENT_W{1'b0}};
            end
        end else if (CE_PIX) begin
            dly_r[0] <= head_s;
            for (int i = 1; i < MAX_FINE; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end else begin
            for (int i = 0; i < MAX_FINE; i++) begin
                dly_r[i] <= dly_r[i];
            end
        end
    end

    // Registered pixel, attribute and opacity outputs.
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            PIX    <= 4'd0;
            PCOL   <= {COL_W{1'b0}};
            OPAQUE <= 1'b0;
        end else if (CE_PIX) begin
            PIX    <= sel_s[ENT_W-1 -: 4];
            PCOL   <= sel_s[COL_W-1:0];
            OPAQUE <= (sel_s[ENT_W-1 -: 4] != 4'd0);
        end else begin
            PIX    <= PIX;
            PCOL   <= PCOL;
            OPAQUE <= OPAQUE;
        end
    end

endmodule

// File: tb/tb_k051962_tile_serializer.sv
// Bench for k051962_tile_serializer: directed scenarios plus random traffic,
// checked against a pixel-history reference model.
module tb_k051962_tile_serializer;

    localparam int CW = 8;

    logic          M24 = 1'b0;
    logic          RES = 1'b0;
    logic          CE_PIX = 1'b0;
    logic          LOAD = 1'b0;
    logic          BEN = 1'b0;
    logic          HFLIP = 1'b0;
    logic [CW-1:0] COL = 8'd0;
    logic [31:0]   VC_DATA = 32'd0;
    logic [2:0]    FINE = 3'd0;
    logic [3:0]    PIX;
    logic [CW-1:0] PCOL;
    logic          OPAQUE;
    logic          TILE_DONE;

    k051962_tile_serializer #(.COL_W(CW), .MAX_FINE(7)) dut (
        .M24(M24), .RES(RES), .CE_PIX(CE_PIX), .LOAD(LOAD), .BEN(BEN),
        .HFLIP(HFLIP), .COL(COL), .VC_DATA(VC_DATA), .FINE(FINE),
        .PIX(PIX), .PCOL(PCOL), .OPAQUE(OPAQUE), .TILE_DONE(TILE_DONE)
    );

    always #5 M24 = ~M24;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the tile as an array of pixels, and a history of what
    // was at the head of the tile on each pixel tick. Output = head FINE ticks ago.
    logic [3:0]    mp [8];
    logic [CW-1:0] mcol;
    int            mcnt;
    logic [11:0]   hist [$];
    logic [3:0]    exp_pix;
    logic [CW-1:0] exp_col;
    logic          exp_opq;
    logic          exp_done;
    logic [2:0]    cur_fine = 3'd0;

    function automatic logic [3:0] ref_pixel(input logic [31:0] d, input logic flip, input int n);
        int b;
        b = flip ? n : 7 - n;
        return {d[24+b], d[16+b], d[8+b], d[b]};
    endfunction

    task automatic model_reset();
        mcnt = 0;
        mcol = 8'd0;
        hist.delete();
        exp_pix = 4'd0;
        exp_col = 8'd0;
        exp_opq = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic model_edge();
        logic [11:0] h;
        logic [11:0] sel;
        int          idx;
        h = (mcnt > 0) ? {mp[8-mcnt], mcol} : 12'd0;
        hist.push_back(h);
        if (hist.size() > 16) hist.delete(0);
        idx = hist.size() - 1 - int'(FINE);
        sel = (idx >= 0) ? hist[idx] : 12'd0;
        exp_pix = sel[11:8];
        exp_col = sel[7:0];
        exp_opq = (sel[11:8] != 4'd0);
        if (LOAD) begin
            for (int n = 0; n < 8; n++) mp[n] = BEN ? ref_pixel(VC_DATA, HFLIP, n) : 4'd0;
            mcol = BEN ? COL : 8'd0;
            mcnt = 8;
            exp_done = 1'b0;
        end else if (mcnt > 0) begin
            mcnt--;
            exp_done = (mcnt == 0);
        end else begin
            exp_done = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pix"}, 32'(PIX), 32'(exp_pix));
        check({tag, ".pcol"}, 32'(PCOL), 32'(exp_col));
        check({tag, ".opaque"}, 32'(OPAQUE), 32'(exp_opq));
        check({tag, ".done"}, 32'(TILE_DONE), 32'(exp_done));
    endtask

    task automatic cycle(input bit ce, input bit load, input bit ben, input bit flip,
                         input logic [7:0] col, input logic [31:0] data);
        @(negedge M24);
        CE_PIX = ce; LOAD = load; BEN = ben; HFLIP = flip;
        COL = col; VC_DATA = data; FINE = cur_fine;
        @(posedge M24);
        if (ce) model_edge();
        #1;
        check_outputs(ce ? "ce" : "hold");
    endtask

    // Idle M24 cycles carry random (ignored) LOAD/data, then one CE tick.
    task automatic tick(input bit load, input bit ben, input bit flip,
                        input logic [7:0] col, input logic [31:0] data, input int gap);
        for (int g = 0; g < gap; g++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                  8'($urandom), 32'($urandom));
        end
        cycle(1'b1, load, ben, flip, col, data);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 8'd0, 32'd0, 3);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge M24);
        #1;
        check_outputs("reset");
        @(negedge M24);
        RES = 1'b1;

        // Single tile, no flip then flip, FINE=0.
        tick(1'b1, 1'b1, 1'b0, 8'h5A, 32'hFF00F00F, 3);
        idle_ticks(10);
        tick(1'b1, 1'b1, 1'b1, 8'h5A, 32'hFF00F00F, 3);
        idle_ticks(10);

        // Fine scroll of 5.
        cur_fine = 3'd5;
        tick(1'b1, 1'b1, 1'b0, 8'hC3, 32'h12345678, 3);
        idle_ticks(15);

        // Back-to-back tiles every 8 ticks, at two scroll settings.
        for (int f = 0; f < 2; f++) begin
            cur_fine = (f == 0) ? 3'd0 : 3'd3;
            for (int t = 0; t < 4; t++) begin
                tick(1'b1, 1'b1, 1'(t), 8'(8'h10 + t), 32'($urandom), 3);
                for (int k = 0; k < 7; k++) tick(1'b0, 1'b1, 1'b0, 8'd0, 32'd0, 3);
            end
            idle_ticks(12);
        end

        // Reload at pixel 3 truncates the tile.
        cur_fine = 3'd0;
        tick(1'b1, 1'b1, 1'b0, 8'hA1, 32'hDEADBEEF, 3);
        idle_ticks(3);
        tick(1'b1, 1'b1, 1'b0, 8'hB2, 32'hCAFEF00D, 3);
        idle_ticks(10);

        // BEN=0: transparent tile, attribute 0.
        tick(1'b1, 1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 3);
        idle_ticks(10);

        // Asynchronous reset mid-tile.
        cur_fine = 3'd2;
        tick(1'b1, 1'b1, 1'b0, 8'h77, 32'hFFFFFFFF, 3);
        idle_ticks(4);
        @(negedge M24);
        CE_PIX = 1'b0;
        #2;
        RES = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge M24);
        RES = 1'b1;
        idle_ticks(3);

        // Random traffic: random CE spacing, loads and scroll changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) cur_fine = 3'($urandom_range(0, 7));
            tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                 1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom),
                 $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
